// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_arb_pkg
// Brief   : Grant encodings, LOG2 helper and request types for fifo_arb.
// Revision: 1.0
// ============================================================================

`ifndef FIFO_ARB_DEFINES_SVH
`define FIFO_ARB_DEFINES_SVH
`define LOG2(x)  $clog2(x)
`define GNT_NONE 2'd0
`define GNT_W0   2'd1
`define GNT_W1   2'd2
`define GNT_RD   2'd3
`endif

package fifo_arb_pkg;

    typedef logic [1:0] gnt_t;

    typedef struct packed {
        logic rd;
        logic w1;
        logic w0;
    } req_t;

    localparam logic [1:0] GNT_NONE = `GNT_NONE;
    localparam logic [1:0] GNT_W0   = `GNT_W0;
    localparam logic [1:0] GNT_W1   = `GNT_W1;
    localparam logic [1:0] GNT_RD   = `GNT_RD;

endpackage

`default_nettype wire

// File: rtl/fifo_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fifo
// Brief   : Single-port circular FIFO with registered read data and count.
// Revision: 1.0
// ============================================================================

module fifo
    import fifo_arb_pkg::*;
#(
    parameter int SIZE    = 16,
    parameter int DATA_WD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [DATA_WD-1:0]   wr_dat_i,
    input  logic                 rd_en_i,
    output logic                 rd_val_o,
    output logic [DATA_WD-1:0]   rd_dat_o,
    output logic [`LOG2(SIZE):0] cnt_o
);

    localparam int AW = `LOG2(SIZE);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

    logic [DATA_WD-1:0] mem_q [SIZE];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               rd_val_q;
    logic [DATA_WD-1:0] rd_dat_q, rd_dat_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_dat_d = rd_dat_q;
        // Explicit wrap keeps non-power-of-two depths gap-free.
        if (wr_en_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + CW'(1);
        end
        if (rd_en_i) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - CW'(1);
            rd_dat_d = mem_q[rd_ptr_q];
        end
        if (wr_en_i && rd_en_i) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_val_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_val_q <= rd_en_i;
            rd_dat_q <= rd_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    assign rd_val_o = rd_val_q;
    assign rd_dat_o = rd_dat_q;
    assign cnt_o    = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_arb.sv
`default_nettype none
// ============================================================================
// Module  : fifo_arb
// Brief   : Round-robin arbiter sharing one single-port FIFO between two
//           writers and one reader.
// Revision: 1.0
// ============================================================================

module fifo_arb
    import fifo_arb_pkg::*;
#(
    parameter int SIZE    = 16,
    parameter int DATA_WD = 8,
    parameter int AF_LVL  = SIZE - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr0_val_i,
    input  logic [DATA_WD-1:0]   wr0_dat_i,
    output logic                 wr0_rdy_o,
    input  logic                 wr1_val_i,
    input  logic [DATA_WD-1:0]   wr1_dat_i,
    output logic                 wr1_rdy_o,
    input  logic                 rd_req_i,
    output logic                 rd_rdy_o,
    output logic                 rd_val_o,
    output logic [DATA_WD-1:0]   rd_dat_o,
    output logic [`LOG2(SIZE):0] wd_usd_o,
    output logic                 ful_o,
    output logic                 ept_o,
    output logic                 afl_o
);

    localparam int CW = `LOG2(SIZE) + 1;

    req_t               req;
    logic [1:0]         last_q, last_d;
    logic [1:0]         gnt_d;
    logic [1:0]         gnt;
    logic               fifo_wr_en;
    logic               fifo_rd_en;
    logic [DATA_WD-1:0] fifo_wr_dat;
    logic               fifo_rst_n;

    always_comb begin
        req    = '0;
        req.w0 = wr0_val_i && !ful_o;
        req.w1 = wr1_val_i && !ful_o;
        req.rd = rd_req_i && !ept_o;
    end

    // Search starts at the requester after the last one granted.
    always_comb begin
        gnt_d = GNT_NONE;
        case (last_q)
            GNT_W0: begin
                if      (req.w1) gnt_d = GNT_W1;
                else if (req.rd) gnt_d = GNT_RD;
                else if (req.w0) gnt_d = GNT_W0;
            end
            GNT_W1: begin
                if      (req.rd) gnt_d = GNT_RD;
                else if (req.w0) gnt_d = GNT_W0;
                else if (req.w1) gnt_d = GNT_W1;
            end
            default: begin
                if      (req.w0) gnt_d = GNT_W0;
                else if (req.w1) gnt_d = GNT_W1;
                else if (req.rd) gnt_d = GNT_RD;
            end
        endcase
    end

    assign gnt    = rst ? GNT_NONE : gnt_d;
    assign last_d = (gnt != GNT_NONE) ? gnt : last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_RD;
        end else begin
            last_q <= last_d;
        end
    end

    assign wr0_rdy_o   = (gnt == GNT_W0);
    assign wr1_rdy_o   = (gnt == GNT_W1);
    assign rd_rdy_o    = (gnt == GNT_RD);
    assign fifo_wr_en  = wr0_rdy_o || wr1_rdy_o;
    assign fifo_rd_en  = rd_rdy_o;
    assign fifo_wr_dat = wr1_rdy_o ? wr1_dat_i : wr0_dat_i;
    assign fifo_rst_n  = ~rst;

    fifo #(
        .SIZE    (SIZE),
        .DATA_WD (DATA_WD)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (fifo_rst_n),
        .wr_en_i  (fifo_wr_en),
        .wr_dat_i (fifo_wr_dat),
        .rd_en_i  (fifo_rd_en),
        .rd_val_o (rd_val_o),
        .rd_dat_o (rd_dat_o),
        .cnt_o    (wd_usd_o)
    );

    assign ful_o = (wd_usd_o == CW'(SIZE));
    assign ept_o = (wd_usd_o == '0);
    assign afl_o = (wd_usd_o >= CW'(AF_LVL));

endmodule

`default_nettype wire
